// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants for the push-button conditioning block
package btn_pkg;

    localparam int NUM_BTN             = 7;
    localparam int BTN_RESET_IDX       = 0;
    localparam int DEBOUNCE_CYCLES_SIM = 4;
    localparam int DEBOUNCE_CYCLES_HW  = 250000;
    localparam int RST_STRETCH_DEFAULT = 16;

    // Reset button idles high, every other button idles low.
    localparam logic [NUM_BTN-1:0] STABLE_INIT_DEFAULT =
        NUM_BTN'(1) << BTN_RESET_IDX;

endpackage

// File: rtl/btn_debounce_cell.sv
// rtl/btn_debounce_cell.sv - per-button synchroniser, debounce counter and edge pulses
module debounce_cell #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 18,
    parameter logic INIT            = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= INIT;
            sync2 <= INIT;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= INIT;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= INIT;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            stable_q <= stable;
            rise     <= stable & ~stable_q;
            fall     <= ~stable & stable_q;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button conditioning with sticky events and stretched core reset
module btn_debounce #(
    parameter int                  NUM_BTN         = btn_pkg::NUM_BTN,
    parameter int                  DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES_HW,
    parameter int                  CNT_W           = 18,
    parameter int                  RST_STRETCH     = btn_pkg::RST_STRETCH_DEFAULT,
    parameter logic [NUM_BTN-1:0]  STABLE_INIT     = btn_pkg::STABLE_INIT_DEFAULT
) (
    input  logic               clk_25mhz,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_stable,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall,
    output logic [NUM_BTN-1:0] evt_pending,
    input  logic [NUM_BTN-1:0] evt_clear,
    output logic               cpu_reset_n
);

    localparam int RW = $clog2(RST_STRETCH + 1);
    localparam logic [RW-1:0] RCNT_LOAD = RW'(RST_STRETCH);

    logic [RW-1:0] rcnt;
    logic          rst_cause;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .INIT            (STABLE_INIT[i])
        ) u_cell (
            .clk    (clk_25mhz),
            .rst_n  (reset_n),
            .raw    (btn_raw[i]),
            .stable (btn_stable[i]),
            .rise   (btn_rise[i]),
            .fall   (btn_fall[i])
        );
    end

    // Set beats clear so a press landing on the clear cycle is never lost.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            evt_pending <= '0;
        end else begin
            evt_pending <= (evt_pending & ~evt_clear) | btn_rise;
        end
    end

    assign rst_cause = ~btn_stable[btn_pkg::BTN_RESET_IDX];

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            rcnt        <= RCNT_LOAD;
            cpu_reset_n <= 1'b0;
        end else if (rst_cause) begin
            rcnt        <= RCNT_LOAD;
            cpu_reset_n <= 1'b0;
        end else if (rcnt != '0) begin
            rcnt        <= rcnt - 1'b1;
            cpu_reset_n <= 1'b0;
        end else begin
            cpu_reset_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;

    localparam int N = 7;

    logic         clk_25mhz = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_stable;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;
    logic [N-1:0] evt_pending;
    logic [N-1:0] evt_clear;
    logic         cpu_reset_n;

    int checks = 0;
    int errors = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    btn_debounce #(
        .NUM_BTN         (N),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .RST_STRETCH     (8),
        .STABLE_INIT     (7'b0000001)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_stable  (btn_stable),
        .btn_rise    (btn_rise),
        .btn_fall    (btn_fall),
        .evt_pending (evt_pending),
        .evt_clear   (evt_clear),
        .cpu_reset_n (cpu_reset_n)
    );

    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk_25mhz);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        btn_raw   = 7'b0000001;
        evt_clear = '0;
        step(3);
        check("rst_stable", 32'(btn_stable), 32'h01);
        check("rst_rise", 32'(btn_rise), 32'h0);
        check("rst_fall", 32'(btn_fall), 32'h0);
        check("rst_evt", 32'(evt_pending), 32'h0);
        check("rst_crn", 32'(cpu_reset_n), 32'h0);

        // reset release: core reset stays low for 8 edges, high on edge 9
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check($sformatf("rel_crn_e%0d", k), 32'(cpu_reset_n), 32'(k >= 9));
            check($sformatf("rel_stable_e%0d", k), 32'(btn_stable), 32'h01);
            check($sformatf("rel_pulses_e%0d", k), 32'(btn_rise | btn_fall), 32'h0);
        end

        // clean press on bit 3
        btn_raw[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check($sformatf("press_stable3_e%0d", k), 32'(btn_stable[3]), 32'(k >= 6));
            check($sformatf("press_rise3_e%0d", k), 32'(btn_rise[3]), 32'(k == 7));
            check($sformatf("press_evt3_e%0d", k), 32'(evt_pending[3]), 32'(k >= 8));
        end

        // glitch on bit 2: three cycles high is discarded
        for (int k = 1; k <= 9; k++) begin
            btn_raw[2] = (k <= 3);
            step(1);
            check($sformatf("glitch_stable2_e%0d", k), 32'(btn_stable[2]), 32'h0);
            check($sformatf("glitch_rise2_e%0d", k), 32'(btn_rise[2]), 32'h0);
            check($sformatf("glitch_evt2_e%0d", k), 32'(evt_pending[2]), 32'h0);
        end

        // bounce on bit 5: 1,0,1,1,0 then held 1 from edge 6
        for (int k = 1; k <= 13; k++) begin
            btn_raw[5] = (k == 1) || (k == 3) || (k == 4) || (k >= 6);
            step(1);
            check($sformatf("bounce_stable5_e%0d", k), 32'(btn_stable[5]), 32'(k >= 11));
            check($sformatf("bounce_rise5_e%0d", k), 32'(btn_rise[5]), 32'(k == 12));
        end

        // release bit 3, then press again and race clear against the new rise
        btn_raw[3] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("rel3_fall_e%0d", k), 32'(btn_fall[3]), 32'(k == 7));
            check($sformatf("rel3_evt_e%0d", k), 32'(evt_pending[3]), 32'h1);
        end
        btn_raw[3] = 1'b1;
        step(7);
        check("race_rise3", 32'(btn_rise[3]), 32'h1);
        evt_clear = 7'b0001000;
        step(1);
        check("race_evt3_set_wins", 32'(evt_pending[3]), 32'h1);
        check("race_rise3_gone", 32'(btn_rise[3]), 32'h0);
        step(1);
        check("clear_evt3", 32'(evt_pending[3]), 32'h0);
        evt_clear = 7'b0000100;
        step(1);
        check("clear_zero_bit2", 32'(evt_pending), 32'h20);
        evt_clear = 7'b0100000;
        step(1);
        check("clear_evt5", 32'(evt_pending), 32'h00);
        evt_clear = '0;

        // reset button held low 10 cycles then released
        for (int k = 1; k <= 27; k++) begin
            btn_raw[0] = (k >= 11);
            step(1);
            check($sformatf("rbtn_stable0_e%0d", k), 32'(btn_stable[0]), 32'(!(k >= 6 && k <= 15)));
            check($sformatf("rbtn_crn_e%0d", k), 32'(cpu_reset_n), 32'(!(k >= 7 && k <= 24)));
            check($sformatf("rbtn_fall0_e%0d", k), 32'(btn_fall[0]), 32'(k == 7));
            check($sformatf("rbtn_rise0_e%0d", k), 32'(btn_rise[0]), 32'(k == 17));
            check($sformatf("rbtn_evt0_e%0d", k), 32'(evt_pending[0]), 32'(k >= 18));
        end

        // asynchronous reset mid-count on bit 4 with bit 3 still held
        btn_raw[4] = 1'b1;
        step(3);
        reset_n = 1'b0;
        #1;
        check("midrst_stable", 32'(btn_stable), 32'h01);
        check("midrst_evt", 32'(evt_pending), 32'h0);
        check("midrst_crn", 32'(cpu_reset_n), 32'h0);
        check("midrst_pulses", 32'(btn_rise | btn_fall), 32'h0);
        step(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check($sformatf("post_stable4_e%0d", k), 32'(btn_stable[4]), 32'(k >= 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions the raw board push-buttons before they reach the top-level CPU/LED design.
- Per button it does three things: two-flop synchronisation, counter-based debounce, and one-cycle rise/fall pulses.
- It holds sticky "pressed" events until the CPU clears them.
- btn[0] is the board's active-low reset button. The block turns its debounced level into a stretched, glitch-free cpu_reset_n for the core.

Parameters:
- NUM_BTN, 7, number of button inputs; bit 0 is the reset button.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level (10 ms at 25 MHz); must be >= 2.
- CNT_W, 18, debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.
- RST_STRETCH, 16, cycles cpu_reset_n stays low after its cause ends; must be >= 1.
- STABLE_INIT, 7'b0000001, reset value of btn_stable; reset button idles high.

Ports:
- clk_25mhz  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- btn_raw  in  NUM_BTN  asynchronous board buttons.
- btn_stable  out  NUM_BTN  debounced level.
- btn_rise  out  NUM_BTN  one-cycle pulse when btn_stable goes 0->1.
- btn_fall  out  NUM_BTN  one-cycle pulse when btn_stable goes 1->0.
- evt_pending  out  NUM_BTN  sticky flag, set by btn_rise.
- evt_clear  in  NUM_BTN  per-bit clear for evt_pending; synchronous to clk_25mhz.
- cpu_reset_n  out  1  stretched active-low reset for the downstream core.

Behaviour:
- Reset is asynchronous and active-low (reset_n); clock is clk_25mhz. All flops reset asynchronously.
- Reset values:
  - btn_stable = STABLE_INIT.
  - Sync flops = STABLE_INIT.
  - Counters = 0.
  - btn_rise = btn_fall = evt_pending = 0.
  - cpu_reset_n = 0.
  - Stretch counter = RST_STRETCH.
- Synchroniser: sync1 <= btn_raw; sync2 <= sync1. No logic is placed between the two flops.
- Debounce, per bit i, each cycle:
  - If sync2[i] == btn_stable[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_stable[i] <= sync2[i], cnt <= 0.
  - Else: cnt <= cnt+1.
- Debounce consequences:
  - A clean level change reaches btn_stable on the (DEBOUNCE_CYCLES+2)th rising edge after the edge that first samples it.
  - Any mismatch run shorter than DEBOUNCE_CYCLES cycles is discarded.
  - A level that toggles back mid-count restarts the count from 0.
- Pulses:
  - btn_rise/btn_fall are registered and asserted in the cycle after btn_stable changes, for exactly 1 cycle.
  - Both are never high together for the same bit.
- Sticky events:
  - evt_pending[i] <= (evt_pending[i] & ~evt_clear[i]) | btn_rise[i].
  - If set and clear coincide, set wins.
  - Clear of an already-zero bit has no effect.
  - Bit 0 is included, so a reset-button release is reported.
- Reset stretch counter (rcnt):
  - cause = ~btn_stable[0].
  - If cause: rcnt <= RST_STRETCH and cpu_reset_n <= 0.
  - Else if rcnt != 0: rcnt <= rcnt-1 and cpu_reset_n <= 0.
  - Else: cpu_reset_n <= 1.
  - cpu_reset_n is a flop output, never combinational.
  - After reset_n deasserts with btn_raw[0] high, cpu_reset_n rises exactly RST_STRETCH+1 edges later.
  - A new press during stretch reloads rcnt to RST_STRETCH.
- Reset mid-operation: asserting reset_n at any point immediately forces every output to its reset value; in-flight counts are lost.
- Counter arithmetic:
  - cnt is CNT_W bits and never wraps, because it resets at DEBOUNCE_CYCLES-1.
  - rcnt width is $clog2(RST_STRETCH+1).

Decomposition:
- Shared package btn_pkg holds:
  - NUM_BTN.
  - BTN_RESET_IDX = 0.
  - DEBOUNCE_CYCLES_SIM = 4.
  - DEBOUNCE_CYCLES_HW = 250000.
  - RST_STRETCH default.
- One sub-module, debounce_cell, contains the synchroniser, counter, stable flop and rise/fall flops for a single bit. It is instantiated NUM_BTN times via generate.
- The top level adds the sticky event logic and the reset stretcher.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and RST_STRETCH=8.
- Reset release: hold reset_n=0 for 3 cycles with btn_raw=7'b0000001, then release -> btn_stable=7'b0000001 throughout; cpu_reset_n=0 until edge 9 after release, then 1; no pulses.
- Clean press: btn_raw[3] 0->1 held -> btn_stable[3]=1 on edge 6; btn_rise[3] high for exactly the following cycle; evt_pending[3]=1 and stays set.
- Glitch: btn_raw[2] high for 3 cycles, then low -> btn_stable[2], btn_rise[2] and evt_pending[2] remain 0.
- Bounce: btn_raw[5] toggles 1,0,1,1,0 on consecutive cycles, then holds 1 -> btn_stable[5] rises exactly 6 edges after the final 0->1 sample.
- Clear race: pulse evt_clear[3] in the same cycle as a fresh btn_rise[3] -> evt_pending[3] stays 1; evt_clear[3] alone next cycle -> 0.
- Reset button: drive btn_raw[0] low 10 cycles, then high -> cpu_reset_n goes 0 one cycle after btn_stable[0] falls (edge 7); returns to 1 nine cycles after btn_stable[0] rises; btn_fall[0] and btn_rise[0] each pulse once; evt_pending[0]=1.
